data_mem_responder: RTL and testbench

//  Responder side of the CPU data-memory port. Serves m_data_addr/m_data_wdata/m_data_byteen:
//   - combinational word read
//   - byte-enabled synchronous write

---
 rtl/mips_mem_pkg.sv | 47 ++++
 rtl/trace_fifo.sv | 69 ++++++
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared data-memory definitions: default geometry, byte-enable encodings,
// the trace record layout and the byte-enable legality rule.
package mips_mem_pkg;

    // Default data-memory geometry: 3072 words starting at byte address 0.
    localparam int          DM_DEPTH = 3072;
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;

    // Byte-enable encodings the core may present.
    localparam logic [3:0] BYTEEN_NONE    = 4'b0000;
    localparam logic [3:0] BYTEEN_WORD    = 4'b1111;
    localparam logic [3:0] BYTEEN_HALF_LO = 4'b0011;
    localparam logic [3:0] BYTEEN_HALF_HI = 4'b1100;
    localparam logic [3:0] BYTEEN_BYTE0   = 4'b0001;
    localparam logic [3:0] BYTEEN_BYTE1   = 4'b0010;
    localparam logic [3:0] BYTEEN_BYTE2   = 4'b0100;
    localparam logic [3:0] BYTEEN_BYTE3   = 4'b1000;

    // One trace record per committed store (96 bits).
    typedef struct packed {
        logic [31:0] pc;    // PC of the store instruction
        logic [31:0] addr;  // word-aligned byte address
        logic [31:0] data;  // full word after the byte merge
    } trace_rec_t;

    // A byte-enable pattern is legal when its lanes match the low address bits:
    // words are fully aligned, halves pick their lane with addr[1], and single
    // bytes pick their lane with addr[1:0]. No enables at all is always legal.
    function automatic logic byteen_legal(input logic [3:0] byteen,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (byteen)
            BYTEEN_NONE:    ok = 1'b1;
            BYTEEN_WORD:    ok = (addr_lo == 2'd0);
            BYTEEN_HALF_LO: ok = (addr_lo[1] == 1'b0);
            BYTEEN_HALF_HI: ok = (addr_lo[1] == 1'b1);
            BYTEEN_BYTE0:   ok = (addr_lo == 2'd0);
            BYTEEN_BYTE1:   ok = (addr_lo == 2'd1);
            BYTEEN_BYTE2:   ok = (addr_lo == 2'd2);
            BYTEEN_BYTE3:   ok = (addr_lo == 2'd3);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO of trace records with a valid/ready drain port.
//
// Handshake: valid is high whenever the head slot holds a record; head is
// stable while valid && !ready. A record leaves on a posedge where
// valid && ready. ready while empty does nothing. A push while full is only
// accepted if the same edge pops; otherwise the record is dropped and the
// drop output is high for that cycle.
module trace_fifo
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  trace_rec_t push_data,
    output logic       full,
    output logic       drop,
    output logic       valid,
    input  logic       ready,
    output trace_rec_t head
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    trace_rec_t  slots [DEPTH];

    logic empty;
    logic pop;
    logic wr_en;

    // Occupancy flags and the push/pop decisions for this cycle.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        valid = !empty;
        pop   = valid && ready;
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
        head  = valid ? slots[rd_ptr[AW-1:0]] : '0;
    end

    // Pointer update; reset discards every buffered record at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Record storage; slots are only observed through head, which is masked
    // while empty, so they need no reset.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            slots[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: zero-latency word read, byte-enabled store,
// and a trace record for every committed store, drained over valid/ready.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH       = DM_DEPTH,
    parameter logic [31:0] BASE_ADDR   = DM_BASE,
    parameter int          TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow,
    output logic        access_err
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    logic [31:0] mem [DEPTH];

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             has_write;
    logic             legal;
    logic             commit;
    logic             bad_access;
    logic [31:0]      old_word;
    logic [31:0]      new_word;
    trace_rec_t       push_rec;

    logic       fifo_full;
    logic       fifo_drop;
    trace_rec_t head_rec;

    // Address decode, legality, read path and byte merge.
    always_comb begin
        offset     = m_data_addr - BASE_ADDR;
        in_range   = (m_data_addr >= BASE_ADDR) && (offset < SPAN);
        idx        = offset[IDX_W+1:2];
        has_write  = (m_data_byteen != BYTEEN_NONE);
        legal      = byteen_legal(m_data_byteen, m_data_addr[1:0]);
        commit     = has_write && legal && in_range;
        bad_access = !in_range || (has_write && !legal);
        // Reads see the word as it stands before this edge's write.
        old_word   = in_range ? mem[idx] : 32'h0;
        new_word   = old_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) begin
                new_word[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
        end
        push_rec.pc   = m_inst_addr;
        push_rec.addr = {m_data_addr[31:2], 2'b00};
        push_rec.data = new_word;
        m_data_rdata  = old_word;
    end

    // RAM: cleared wholesale on reset, otherwise one merged word per commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= 32'h0;
            end
        end else if (commit) begin
            mem[idx] <= new_word;
        end
    end

    // Sticky error and overflow flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            access_err     <= 1'b0;
            trace_overflow <= 1'b0;
        end else begin
            if (bad_access) begin
                access_err <= 1'b1;
            end
            if (fifo_drop) begin
                trace_overflow <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (commit),
        .push_data (push_rec),
        .full      (fifo_full),
        .drop      (fifo_drop),
        .valid     (trace_valid),
        .ready     (trace_ready),
        .head      (head_rec)
    );

    // Head record fields out to the drain port.
    always_comb begin
        trace_pc   = head_rec.pc;
        trace_addr = head_rec.addr;
        trace_data = head_rec.data;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand-written FIFO
// corner sequences and randomized traffic against a behavioural model.
module tb_data_mem_responder;

  localparam int          DEPTH  = 3072;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int          TDEPTH = 8;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] pc;
  logic        rdy;
  logic [31:0] rdata;
  logic        t_valid;
  logic [31:0] t_pc;
  logic [31:0] t_addr;
  logic [31:0] t_data;
  logic        t_ovf;
  logic        a_err;

  data_mem_responder #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .TRACE_DEPTH (TDEPTH)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .m_data_addr    (addr),
    .m_data_wdata   (wdata),
    .m_data_byteen  (be),
    .m_inst_addr    (pc),
    .m_data_rdata   (rdata),
    .trace_valid    (t_valid),
    .trace_ready    (rdy),
    .trace_pc       (t_pc),
    .trace_addr     (t_addr),
    .trace_data     (t_data),
    .trace_overflow (t_ovf),
    .access_err     (a_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_mem [DEPTH];
  logic [95:0] exp_q[$];
  logic        exp_ovf;
  logic        exp_err;
  logic        exp_fresh;
  bit          model_ok = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
  endfunction

  // Legal patterns: full aligned word, a half shifted to its lane, or one byte at its lane.
  function automatic bit m_legal(input logic [3:0] b, input logic [1:0] lo);
    logic [3:0] half_pat;
    logic [3:0] byte_pat;
    half_pat = (lo[1]) ? 4'b1100 : 4'b0011;
    byte_pat = 4'b0001 << lo;
    if (b == 4'b0000) return 1;
    if (b == 4'b1111) return (lo == 2'd0);
    return (b == half_pat) || (b == byte_pat);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_in_range(a)) return 32'h0;
    return exp_mem[(a - BASE) >> 2];
  endfunction

  // Compare every observable output with the model (state before the coming edge).
  task automatic model_compare();
    if (!model_ok) return;
    check("rdata", rdata, m_read(addr));
    check("trace_valid", 32'(t_valid), 32'(exp_q.size() != 0));
    check("trace_overflow", 32'(t_ovf), 32'(exp_ovf));
    check("access_err", 32'(a_err), 32'(exp_err));
    if (exp_q.size() != 0) begin
      check("trace_pc", t_pc, exp_q[0][95:64]);
      check("trace_addr", t_addr, exp_q[0][63:32]);
      check("trace_data", t_data, exp_q[0][31:0]);
    end else if (exp_fresh) begin
      check("trace_head_zero", t_pc | t_addr | t_data, 32'h0);
    end
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic model_update();
    logic [31:0] nw;
    bit          pop;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
      exp_q.delete();
      exp_ovf   = 0;
      exp_err   = 0;
      exp_fresh = 1;
      model_ok  = 1;
      return;
    end
    if (!model_ok) return;
    pop = (exp_q.size() != 0) && rdy;
    if (!m_in_range(addr) || (be != 0 && !m_legal(be, addr[1:0]))) exp_err = 1;
    if (pop) void'(exp_q.pop_front());
    if (be != 0 && m_legal(be, addr[1:0]) && m_in_range(addr)) begin
      nw = m_read(addr);
      for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = wdata[8*i +: 8];
      exp_mem[(addr - BASE) >> 2] = nw;
      if (exp_q.size() < TDEPTH) exp_q.push_back({pc, addr[31:2], 2'b00, nw});
      else exp_ovf = 1;
      exp_fresh = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic [31:0] p, input logic rd);
    @(negedge clk);
    rst = r; addr = a; wdata = wd; be = b; pc = p; rdy = rd;
    #1;
    model_compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, input logic [31:0] p, input logic rd);
    apply(r, a, wd, b, p, rd);
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
    logic        rdy;
    logic        chk;
    logic        hchk;
    logic [31:0] e_rdata;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t vt [12];

  logic [31:0] st_data [9];
  int          seen;

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; be = '0; pc = '0; rdy = 1'b0;

    //          rst addr        wdata         be       pc          rdy chk hchk rdata         vld  pc          addr       data          err
    vt[0]  = '{1'b0, 32'h0,    32'h0,        4'b0000, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    32'h0,  32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h0,    32'h0,        4'b0000, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    32'h0,  32'h0,        1'b0};
    vt[2]  = '{1'b1, 32'h0,    32'h0,        4'b0000, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0,    32'h0,  32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h2FFC, 32'h0,        4'b0000, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0,    32'h0,  32'h0,        1'b0};
    vt[4]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'b1111, 32'h3000, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0,    32'h0,  32'h0,        1'b0};
    vt[5]  = '{1'b1, 32'h10,   32'h0,        4'b0000, 32'h0,    1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h3000, 32'h10, 32'hDEADBEEF, 1'b0};
    vt[6]  = '{1'b1, 32'h12,   32'h00AA0000, 4'b0100, 32'h3004, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h3000, 32'h10, 32'hDEADBEEF, 1'b0};
    vt[7]  = '{1'b1, 32'h10,   32'h0,        4'b0000, 32'h0,    1'b1, 1'b1, 1'b1, 32'hDEAABEEF, 1'b1, 32'h3004, 32'h10, 32'hDEAABEEF, 1'b0};
    vt[8]  = '{1'b1, 32'h0,    32'h0,        4'b0000, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    32'h0,  32'h0,        1'b0};
    vt[9]  = '{1'b1, 32'h20,   32'hFFFFFFFF, 4'b0110, 32'h3008, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    32'h0,  32'h0,        1'b0};
    vt[10] = '{1'b1, 32'h3000, 32'h12345678, 4'b1111, 32'h300C, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    32'h0,  32'h0,        1'b1};
    vt[11] = '{1'b1, 32'h20,   32'h0,        4'b0000, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    32'h0,  32'h0,        1'b1};

    for (int i = 0; i < 12; i++) begin
      apply(vt[i].rst, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].pc, vt[i].rdy);
      if (vt[i].chk) begin
        check($sformatf("vec%0d_rdata", i), rdata, vt[i].e_rdata);
        check($sformatf("vec%0d_valid", i), 32'(t_valid), 32'(vt[i].e_valid));
        check($sformatf("vec%0d_err", i), 32'(a_err), 32'(vt[i].e_err));
        if (vt[i].hchk) begin
          check($sformatf("vec%0d_pc", i), t_pc, vt[i].e_pc);
          check($sformatf("vec%0d_addr", i), t_addr, vt[i].e_addr);
          check($sformatf("vec%0d_data", i), t_data, vt[i].e_data);
        end
      end
      tick();
    end

    // ---- overflow: nine stores with the drain stalled ----
    step(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      st_data[i] = $urandom;
      step(1'b1, 32'h100 + 32'(4 * i), st_data[i], 4'b1111, 32'h4000 + 32'(4 * i), 1'b0);
    end
    apply(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    check("ovf_sticky", 32'(t_ovf), 32'h1);
    check("ovf_valid", 32'(t_valid), 32'h1);
    tick();
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, 32'h100 + 32'(4 * i), 32'h0, 4'b0000, 32'h0, 1'b0);
      check($sformatf("ovf_word%0d", i), rdata, st_data[i]);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
      check($sformatf("drain_pc%0d", i), t_pc, 32'h4000 + 32'(4 * i));
      check($sformatf("drain_data%0d", i), t_data, st_data[i]);
      tick();
    end
    apply(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    check("drain_empty", 32'(t_valid), 32'h0);
    tick();

    // ---- full FIFO + store + pop in the same cycle, then reset mid-drain ----
    step(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'h200 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'b1111, 32'h5000 + 32'(4 * i), 1'b0);
    step(1'b1, 32'h220, 32'hC0DE0008, 4'b1111, 32'h5020, 1'b1);
    apply(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    check("pushpop_no_ovf", 32'(t_ovf), 32'h0);
    check("pushpop_head", t_pc, 32'h5004);
    tick();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
      if (t_valid) seen++;
      tick();
    end
    check("pushpop_count", 32'(seen), 32'd8);
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h300 + 32'(4 * i), $urandom, 4'b1111, 32'h6000 + 32'(4 * i), 1'b0);
    step(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    step(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    apply(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    check("midreset_valid", 32'(t_valid), 32'h0);
    check("midreset_word", rdata, 32'h0);
    tick();

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic [3:0]  b;
      logic        r;
      logic        rd;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'h3000 + $urandom_range(0, 1023);
      else if (sel <= 2) a = 32'h2FC0 + $urandom_range(0, 63);
      else               a = 32'h0 + $urandom_range(0, 63);
      sel = $urandom_range(0, 9);
      if (sel <= 1) b = 4'b0000;
      else if (sel == 2) b = 4'($urandom_range(0, 15));
      else begin
        case ($urandom_range(0, 6))
          0: begin b = 4'b1111; a[1:0] = 2'd0; end
          1: begin b = 4'b0011; a[1] = 1'b0; end
          2: begin b = 4'b1100; a[1] = 1'b1; end
          3: begin b = 4'b0001; a[1:0] = 2'd0; end
          4: begin b = 4'b0010; a[1:0] = 2'd1; end
          5: begin b = 4'b0100; a[1:0] = 2'd2; end
          default: begin b = 4'b1000; a[1:0] = 2'd3; end
        endcase
        if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(0, 3));
      end
      rd = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 149) != 0);
      step(r, a, $urandom, b, $urandom, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
